// File: rtl/gcttt_pkg.sv
// Shared widths, opcodes and bundle types for the
// decode-to-execute boundary of the 8-register core.
package gcttt_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 3;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB = 5'd2;
  localparam logic [OP_W-1:0] OP_LD  = 5'd8;
  localparam logic [OP_W-1:0] OP_ST  = 5'd9;
  localparam logic [OP_W-1:0] OP_BR  = 5'd12;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_EX
  } fwd_sel_t;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and execute-side valid/ready bundle
// around the ID/EX pipeline register.
interface id_ex_stage_if
  import gcttt_pkg::*;
();

  logic              id_valid;
  logic              id_ready;
  logic [OP_W-1:0]   id_opcode;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_is_load;

  logic              ex_ready;
  logic              ex_valid;
  logic [OP_W-1:0]   ex_opcode;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_we;
  logic              ex_is_load;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;

  modport slave (
    input  id_valid, id_opcode, id_imm,
    input  id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_rd, id_we, id_is_load,
    input  ex_ready,
    output id_ready,
    output ex_valid, ex_opcode, ex_imm,
    output ex_rd, ex_we, ex_is_load,
    output ex_op1, ex_op2
  );

  modport master (
    output id_valid, id_opcode, id_imm,
    output id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_rd, id_we, id_is_load,
    output ex_ready,
    input  id_ready,
    input  ex_valid, ex_opcode, ex_imm,
    input  ex_rd, ex_we, ex_is_load,
    input  ex_op1, ex_op2
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: EX result first,
// then the writeback port, else register-file data.
module operand_fwd_mux
  import gcttt_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_fwd_we,
  input  logic [REG_AW-1:0] ex_fwd_reg,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_fwd_we && ex_fwd_reg == src)
      sel = FWD_EX;
    else if (wb_we && wb_reg == src)
      sel = FWD_WB;
  end

  always_comb begin
    data = rf_data;
    unique case (sel)
      FWD_EX:  data = ex_fwd_data;
      FWD_WB:  data = wb_data;
      default: data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding,
// load-use bubbling, stall hold with wb snoop, and flush.
module id_ex_stage
  import gcttt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_if.slave      bus,
  input  logic [DATA_W-1:0] rf_rd1_data,
  input  logic [DATA_W-1:0] rf_rd2_data,
  input  logic              ex_fwd_we,
  input  logic [REG_AW-1:0] ex_fwd_reg,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush
);

  id_ex_t            slot;
  logic              valid;
  logic              advance;
  logic              load_use;
  logic              capture;
  logic              snoop1;
  logic              snoop2;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  fwd_sel_t          sel1;
  fwd_sel_t          sel2;

  operand_fwd_mux u_fwd1 (
    .src(bus.id_rs1), .rf_data(rf_rd1_data),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_reg(ex_fwd_reg),
    .ex_fwd_data(ex_fwd_data),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .data(op1), .sel(sel1)
  );

  operand_fwd_mux u_fwd2 (
    .src(bus.id_rs2), .rf_data(rf_rd2_data),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_reg(ex_fwd_reg),
    .ex_fwd_data(ex_fwd_data),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .data(op2), .sel(sel2)
  );

  // An EX-sourced operand is only legal while EX advertises a result.
  always_comb begin
    if (rst)
      assert ((sel1 != FWD_EX || ex_fwd_we) &&
              (sel2 != FWD_EX || ex_fwd_we));
  end

  assign advance = !valid || bus.ex_ready;

  assign load_use = valid && slot.is_load && slot.we &&
                    bus.id_valid &&
                    ((bus.id_rs1_used && bus.id_rs1 == slot.rd) ||
                     (bus.id_rs2_used && bus.id_rs2 == slot.rd));

  assign capture = advance && bus.id_valid && !load_use;

  assign bus.id_ready = advance && !load_use;

  assign snoop1 = slot.rs1_used && wb_we && wb_reg == slot.rs1;
  assign snoop2 = slot.rs2_used && wb_we && wb_reg == slot.rs2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      slot  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      slot  <= '{opcode:   bus.id_opcode,
                 imm:      bus.id_imm,
                 rd:       bus.id_rd,
                 we:       bus.id_we,
                 is_load:  bus.id_is_load,
                 rs1:      bus.id_rs1,
                 rs2:      bus.id_rs2,
                 rs1_used: bus.id_rs1_used,
                 rs2_used: bus.id_rs2_used,
                 op1:      op1,
                 op2:      op2};
    end else if (advance) begin
      valid <= 1'b0;
    end else begin
      // Held operands track register-file writes so release is never stale.
      if (snoop1) slot.op1 <= wb_data;
      if (snoop2) slot.op2 <= wb_data;
    end
  end

  assign bus.ex_valid   = valid;
  assign bus.ex_opcode  = slot.opcode;
  assign bus.ex_imm     = slot.imm;
  assign bus.ex_rd      = slot.rd;
  assign bus.ex_we      = slot.we;
  assign bus.ex_is_load = slot.is_load;
  assign bus.ex_op1     = slot.op1;
  assign bus.ex_op2     = slot.op2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected slot contents
// are queued at capture and compared while the slot is valid.
module tb_id_ex_stage;
  import gcttt_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rf1, rf2, exd, wbd;
  logic        exw, wbw, flush;
  logic [2:0]  exr, wbr;

  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rf_rd1_data(rf1), .rf_rd2_data(rf2),
    .ex_fwd_we(exw), .ex_fwd_reg(exr), .ex_fwd_data(exd),
    .wb_we(wbw), .wb_reg(wbr), .wb_data(wbd),
    .flush(flush)
  );

  typedef struct {
    logic [4:0]  opc;
    logic [31:0] imm;
    logic [2:0]  rd, rs1, rs2;
    logic        u1, u2, we, ld;
    logic [31:0] op1, op2;
  } ent_t;

  ent_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res(input logic [2:0] s,
                                      input logic [31:0] rf);
    if (exw && exr == s) return exd;
    if (wbw && wbr == s) return wbd;
    return rf;
  endfunction

  task automatic idle_inputs;
    bus.id_valid = 0; bus.id_opcode = '0; bus.id_imm = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.id_rd = '0; bus.id_we = 0; bus.id_is_load = 0;
    exw = 0; exr = '0; exd = '0;
    wbw = 0; wbr = '0; wbd = '0;
    flush = 0;
  endtask

  task automatic set_id(input logic [4:0] opc, input logic [31:0] imm,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic u1, input logic u2,
                        input logic [2:0] rd, input logic we,
                        input logic ld);
    bus.id_valid = 1; bus.id_opcode = opc; bus.id_imm = imm;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_rs1_used = u1; bus.id_rs2_used = u2;
    bus.id_rd = rd; bus.id_we = we; bus.id_is_load = ld;
  endtask

  task automatic cyc;
    ent_t e;
    logic lu, rdy;
    @(negedge clk);
    lu = 0;
    if (q.size() != 0)
      lu = q[0].ld && q[0].we && bus.id_valid &&
           ((bus.id_rs1_used && bus.id_rs1 == q[0].rd) ||
            (bus.id_rs2_used && bus.id_rs2 == q[0].rd));
    rdy = (q.size() == 0 || bus.ex_ready) && !lu;
    chk("id_ready", 32'(bus.id_ready), 32'(rdy));
    chk("ex_valid", 32'(bus.ex_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("ex_opcode", 32'(bus.ex_opcode), 32'(q[0].opc));
      chk("ex_imm", bus.ex_imm, q[0].imm);
      chk("ex_rd", 32'(bus.ex_rd), 32'(q[0].rd));
      chk("ex_we", 32'(bus.ex_we), 32'(q[0].we));
      chk("ex_is_load", 32'(bus.ex_is_load), 32'(q[0].ld));
      chk("ex_op1", bus.ex_op1, q[0].op1);
      chk("ex_op2", bus.ex_op2, q[0].op2);
    end
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && bus.ex_ready) begin
        void'(q.pop_front());
      end else if (q.size() != 0) begin
        if (q[0].u1 && wbw && wbr == q[0].rs1) q[0].op1 = wbd;
        if (q[0].u2 && wbw && wbr == q[0].rs2) q[0].op2 = wbd;
      end
      if (bus.id_valid && rdy) begin
        e.opc = bus.id_opcode; e.imm = bus.id_imm;
        e.rd = bus.id_rd; e.rs1 = bus.id_rs1; e.rs2 = bus.id_rs2;
        e.u1 = bus.id_rs1_used; e.u2 = bus.id_rs2_used;
        e.we = bus.id_we; e.ld = bus.id_is_load;
        e.op1 = res(bus.id_rs1, rf1);
        e.op2 = res(bus.id_rs2, rf2);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    bus.ex_ready = 1;
    rf1 = '0; rf2 = '0;
    rst = 1;
    #1 rst = 0;
    #10;
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_op1", bus.ex_op1, 32'd0);
    chk("rst_op2", bus.ex_op2, 32'd0);
    chk("rst_imm", bus.ex_imm, 32'd0);
    chk("rst_ready", 32'(bus.id_ready), 32'd1);
    @(negedge clk) rst = 1;
    @(posedge clk) #1;

    // EX beats WB on the same register
    set_id(OP_ADD, 32'h10, 3'd3, 3'd1, 1, 1, 3'd6, 1, 0);
    exw = 1; exr = 3'd3; exd = 32'hAAAA0001;
    wbw = 1; wbr = 3'd3; wbd = 32'h5;
    rf1 = 32'h7; rf2 = 32'h11;
    cyc();
    chk("fwd_ex_op1", bus.ex_op1, 32'hAAAA0001);
    set_id(OP_SUB, 32'h20, 3'd4, 3'd3, 1, 1, 3'd7, 1, 0);
    exr = 3'd4; exd = 32'h1111;
    wbr = 3'd3; wbd = 32'h2222;
    rf1 = 32'h33; rf2 = 32'h44;
    cyc();
    set_id(OP_ADD, 32'h0, 3'd0, 3'd0, 1, 1, 3'd5, 1, 0);
    exw = 0; wbw = 1; wbr = 3'd0; wbd = 32'hCAFE;
    rf1 = 32'h1; rf2 = 32'h2;
    cyc();
    idle_inputs();
    cyc();

    // load-use: one bubble, then operand arrives via wb
    set_id(OP_LD, 32'h4, 3'd1, 3'd0, 1, 0, 3'd2, 1, 1);
    rf1 = 32'h100;
    cyc();
    set_id(OP_ADD, 32'h0, 3'd0, 3'd2, 0, 1, 3'd3, 1, 0);
    rf2 = 32'h9;
    #1 chk("lu_ready", 32'(bus.id_ready), 32'd0);
    cyc();
    chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
    wbw = 1; wbr = 3'd2; wbd = 32'h1234;
    cyc();
    chk("lu_op2", bus.ex_op2, 32'h1234);
    idle_inputs();
    cyc();

    // hold with wb snoop
    set_id(OP_ADD, 32'h0, 3'd5, 3'd6, 1, 1, 3'd1, 1, 0);
    rf1 = 32'h55; rf2 = 32'h66;
    cyc();
    set_id(OP_SUB, 32'h8, 3'd2, 3'd3, 1, 1, 3'd4, 1, 0);
    bus.ex_ready = 0;
    cyc();
    wbw = 1; wbr = 3'd5; wbd = 32'hDEAD;
    cyc();
    wbw = 0;
    cyc();
    chk("snoop_op1", bus.ex_op1, 32'hDEAD);
    bus.ex_ready = 1;
    cyc();
    idle_inputs();
    cyc();

    // flush vs capture
    set_id(OP_ADD, 32'h5, 3'd1, 3'd2, 1, 1, 3'd3, 1, 0);
    rf1 = 32'hA1; rf2 = 32'hB2;
    flush = 1;
    cyc();
    chk("flush_nocap", 32'(bus.ex_valid), 32'd0);
    flush = 0;
    cyc();
    chk("cap_valid", 32'(bus.ex_valid), 32'd1);
    idle_inputs();
    bus.ex_ready = 0;
    wbw = 1; wbr = 3'd1; wbd = 32'hBEEF;
    flush = 1;
    cyc();
    chk("flush_hold", 32'(bus.ex_valid), 32'd0);
    idle_inputs();
    bus.ex_ready = 1;
    cyc();

    // unused source cannot cause a load-use stall
    set_id(OP_LD, 32'h0, 3'd0, 3'd0, 1, 0, 3'd4, 1, 1);
    rf1 = 32'h40;
    cyc();
    set_id(OP_ADD, 32'h0, 3'd4, 3'd1, 0, 1, 3'd5, 1, 0);
    rf2 = 32'h61;
    #1 chk("unused_ready", 32'(bus.id_ready), 32'd1);
    cyc();
    chk("unused_cap", 32'(bus.ex_valid), 32'd1);
    idle_inputs();
    cyc();

    // asynchronous reset while holding
    set_id(OP_ADD, 32'h0, 3'd1, 3'd2, 1, 1, 3'd6, 1, 0);
    rf1 = 32'h77;
    cyc();
    idle_inputs();
    bus.ex_ready = 0;
    cyc();
    #2 rst = 0;
    #1;
    chk("arst_valid", 32'(bus.ex_valid), 32'd0);
    chk("arst_op1", bus.ex_op1, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1;
    bus.ex_ready = 1;
    @(posedge clk) #1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
